// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode enum, FSM states, opcode width.
package seq_alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_SHL  = 3'd2,
    ALU_SHR  = 3'd3,
    ALU_MUL  = 3'd4,
    ALU_DIV  = 3'd5,
    ALU_ILL6 = 3'd6,
    ALU_ILL7 = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // Multiply and divide go through the iterative engine; everything else is single-cycle.
  function automatic logic is_multicycle(input alu_op_e op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative engine: shift-add multiplier / restoring divider, one bit per cycle.
// The first bit is processed on the start edge, so after WIDTH edges the
// magnitude result is complete and the sign fix-up is applied combinationally,
// ready to be captured by the parent on the following edge.
module seq_alu_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_div,
  input  logic               sign,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  logic [2*WIDTH-1:0] p_r, p_cur_s, p_step_s;
  logic [WIDTH-1:0]   m_r, m_cur_s, a_mag_s, b_mag_s;
  logic [CW-1:0]      cnt_r;
  logic               busy_r, is_div_r, neg_lo_r, neg_hi_r;
  logic               a_neg_s, b_neg_s, div_cur_s;

  // One iteration: multiply = conditional add then shift right; divide = shift left, trial subtract.
  function automatic logic [2*WIDTH-1:0] md_step(input logic       dv,
                                                 input logic [2*WIDTH-1:0] p,
                                                 input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    sum     = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    shifted = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    trial   = shifted - {1'b0, m};
    if (!dv) begin
      md_step = {sum, p[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      md_step = {trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    end else begin
      md_step = {shifted[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
    end
  endfunction

  // Operand magnitudes and the working value for this cycle's step.
  always_comb begin
    a_neg_s   = sign && a[WIDTH-1];
    b_neg_s   = sign && b[WIDTH-1];
    a_mag_s   = a_neg_s ? -a : a;
    b_mag_s   = b_neg_s ? -b : b;
    div_cur_s = start ? is_div : is_div_r;
    if (start) begin
      p_cur_s = {{WIDTH{1'b0}}, (is_div ? a_mag_s : b_mag_s)};
      m_cur_s = is_div ? b_mag_s : a_mag_s;
    end else begin
      p_cur_s = p_r;
      m_cur_s = m_r;
    end
    p_step_s = md_step(div_cur_s, p_cur_s, m_cur_s);
  end

  // Iteration state: latch operands on start, then step until WIDTH bits are done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r      <= {(2*WIDTH){1'b0}};
      m_r      <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b0;
      is_div_r <= 1'b0;
      neg_lo_r <= 1'b0;
      neg_hi_r <= 1'b0;
    end else if (start) begin
      p_r      <= p_step_s;
      m_r      <= m_cur_s;
      cnt_r    <= CW'(1);
      busy_r   <= 1'b1;
      is_div_r <= is_div;
      neg_lo_r <= a_neg_s ^ b_neg_s;
      neg_hi_r <= is_div ? a_neg_s : (a_neg_s ^ b_neg_s);
    end else if (busy_r && (cnt_r != CNT_LAST)) begin
      p_r   <= p_step_s;
      cnt_r <= cnt_r + CW'(1);
    end else if (done) begin
      busy_r <= 1'b0;
    end
  end

  assign done = busy_r && (cnt_r == CNT_LAST);

  // Final sign correction: whole product for multiply, quotient/remainder separately for divide.
  always_comb begin
    if (!is_div_r) begin
      result = neg_lo_r ? -p_r : p_r;
    end else begin
      result[WIDTH-1:0]       = neg_lo_r ? -p_r[WIDTH-1:0] : p_r[WIDTH-1:0];
      result[2*WIDTH-1:WIDTH] = neg_hi_r ? -p_r[2*WIDTH-1:WIDTH] : p_r[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/shift, WIDTH-cycle multiply/divide,
// valid/ready handshake on both sides, result held until consumed.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  input  logic [OP_W-1:0]    operation,
  input  logic               sign,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               flag
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  alu_state_e         state_r, state_nxt_s;
  alu_op_e            op_s;
  logic               accept_s, md_start_s, md_done_s;
  logic [2*WIDTH-1:0] md_result_s, result_r;
  logic [2*WIDTH:0]   alu_out_s;
  logic               flag_r, out_valid_r, in_ready_r;
  logic               div_zero_r, div_ovf_r;
  logic [WIDTH-1:0]   div_op1_r;

  // Single-cycle operations; returns {flag, upper half, lower half}.
  function automatic logic [2*WIDTH:0] alu_eval(input alu_op_e op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic sgn);
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] low;
    logic             flg;
    logic             big;
    logic             ill;
    wide = {(WIDTH+1){1'b0}};
    low  = {WIDTH{1'b0}};
    flg  = 1'b0;
    ill  = 1'b0;
    big  = (32'(b) >= 32'(WIDTH));
    case (op)
      ALU_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        low  = wide[WIDTH-1:0];
        flg  = sgn ? ((a[WIDTH-1] == b[WIDTH-1]) && (low[WIDTH-1] != a[WIDTH-1])) : wide[WIDTH];
      end
      ALU_SUB: begin
        wide = {1'b0, a} - {1'b0, b};
        low  = wide[WIDTH-1:0];
        flg  = sgn ? ((a[WIDTH-1] != b[WIDTH-1]) && (low[WIDTH-1] != a[WIDTH-1])) : wide[WIDTH];
      end
      ALU_SHL: begin
        if (big) low = {WIDTH{1'b0}};
        else     low = a << b;
      end
      ALU_SHR: begin
        if (big)      low = sgn ? {WIDTH{a[WIDTH-1]}} : {WIDTH{1'b0}};
        else if (sgn) low = $signed(a) >>> b;
        else          low = a >> b;
      end
      default: begin
        ill = 1'b1;
        flg = 1'b1;
      end
    endcase
    return {flg, ((sgn && low[WIDTH-1] && !ill) ? ALL_ONES : {WIDTH{1'b0}}), low};
  endfunction

  assign op_s      = alu_op_e'(operation);
  assign alu_out_s = alu_eval(op_s, op1, op2, sign);

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start_s),
    .is_div (op_s == ALU_DIV),
    .sign   (sign),
    .a      (op1),
    .b      (op2),
    .done   (md_done_s),
    .result (md_result_s)
  );

  // Next-state logic and accept / engine-start decode.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    md_start_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          accept_s = 1'b1;
          if (is_multicycle(op_s)) begin
            md_start_s  = 1'b1;
            state_nxt_s = BUSY;
          end else begin
            state_nxt_s = DONE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (md_done_s) state_nxt_s = DONE;
        else           state_nxt_s = BUSY;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, handshake outputs and result/flag capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= {(2*WIDTH){1'b0}};
      flag_r      <= 1'b0;
      div_zero_r  <= 1'b0;
      div_ovf_r   <= 1'b0;
      div_op1_r   <= {WIDTH{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
      if (accept_s && md_start_s) begin
        result_r   <= {(2*WIDTH){1'b0}};
        flag_r     <= 1'b0;
        div_zero_r <= (op_s == ALU_DIV) && (op2 == {WIDTH{1'b0}});
        div_ovf_r  <= (op_s == ALU_DIV) && sign && (op1 == MOST_NEG) && (op2 == ALL_ONES);
        div_op1_r  <= op1;
      end else if (accept_s) begin
        {flag_r, result_r} <= alu_out_s;
      end else if ((state_r == BUSY) && md_done_s) begin
        // Divide by zero reports the raw dividend as remainder, even when signed.
        result_r <= div_zero_r ? {div_op1_r, ALL_ONES} : md_result_s;
        flag_r   <= div_zero_r || div_ovf_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign flag      = flag_r;

endmodule

// File: tb/tb_seq_alu.sv
// Directed, table-driven bench for seq_alu at WIDTH=8.
module tb_seq_alu;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   op1 = 8'h00;
  logic [W-1:0]   op2 = 8'h00;
  logic [2:0]     operation = 3'd0;
  logic           sign = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] result;
  logic           flag;

  int tests = 0;
  int fails = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .operation (operation),
    .sign      (sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag      (flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        flg;
    int          lat;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one operation, accept it, scramble inputs, wait (bounded) for out_valid.
  task automatic run_op(input logic [2:0] op, input logic sgn, input logic [7:0] a,
                        input logic [7:0] b, output logic [15:0] res, output logic flg,
                        output int lat);
    @(negedge clk);
    operation = op; sign = sgn; op1 = a; op2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op1 = 8'h5A; op2 = 8'hA5; operation = 3'd1; sign = ~sgn;
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    flg = flag;
  endtask

  // Consume the pending result.
  task automatic complete();
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] r;
    logic        f;
    int          lat;
    int          seen;

    vecs[0]  = '{3'd0, 1'b1, 8'h7F, 8'h01, 16'hFF80, 1'b1, 1};
    vecs[1]  = '{3'd0, 1'b0, 8'hFF, 8'h01, 16'h0000, 1'b1, 1};
    vecs[2]  = '{3'd0, 1'b0, 8'h12, 8'h34, 16'h0046, 1'b0, 1};
    vecs[3]  = '{3'd1, 1'b0, 8'h05, 8'h07, 16'h00FE, 1'b1, 1};
    vecs[4]  = '{3'd1, 1'b1, 8'h80, 8'h01, 16'h007F, 1'b1, 1};
    vecs[5]  = '{3'd1, 1'b1, 8'h05, 8'h07, 16'hFFFE, 1'b0, 1};
    vecs[6]  = '{3'd2, 1'b0, 8'h81, 8'h01, 16'h0002, 1'b0, 1};
    vecs[7]  = '{3'd2, 1'b1, 8'h21, 8'h02, 16'hFF84, 1'b0, 1};
    vecs[8]  = '{3'd3, 1'b1, 8'h90, 8'h09, 16'hFFFF, 1'b0, 1};
    vecs[9]  = '{3'd3, 1'b0, 8'h90, 8'h09, 16'h0000, 1'b0, 1};
    vecs[10] = '{3'd3, 1'b1, 8'h90, 8'h02, 16'hFFE4, 1'b0, 1};
    vecs[11] = '{3'd3, 1'b0, 8'h90, 8'h04, 16'h0009, 1'b0, 1};
    vecs[12] = '{3'd2, 1'b0, 8'hFF, 8'h08, 16'h0000, 1'b0, 1};
    vecs[13] = '{3'd4, 1'b1, 8'hFD, 8'h05, 16'hFFF1, 1'b0, 9};
    vecs[14] = '{3'd4, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 9};
    vecs[15] = '{3'd4, 1'b1, 8'h80, 8'h80, 16'h4000, 1'b0, 9};
    vecs[16] = '{3'd4, 1'b1, 8'h7F, 8'hFF, 16'hFF81, 1'b0, 9};
    vecs[17] = '{3'd5, 1'b0, 8'd200, 8'd7, 16'h041C, 1'b0, 9};
    vecs[18] = '{3'd5, 1'b0, 8'h2A, 8'h00, 16'h2AFF, 1'b1, 9};
    vecs[19] = '{3'd5, 1'b1, 8'h80, 8'hFF, 16'h0080, 1'b1, 9};
    vecs[20] = '{3'd5, 1'b1, 8'hF9, 8'h02, 16'hFFFD, 1'b0, 9};
    vecs[21] = '{3'd5, 1'b1, 8'h07, 8'hFE, 16'h01FD, 1'b0, 9};
    vecs[22] = '{3'd5, 1'b1, 8'hF0, 8'h00, 16'hF0FF, 1'b1, 9};
    vecs[23] = '{3'd6, 1'b0, 8'h12, 8'h34, 16'h0000, 1'b1, 1};
    vecs[24] = '{3'd7, 1'b1, 8'hFF, 8'hFF, 16'h0000, 1'b1, 1};

    // Reset state
    #12;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_flag", 32'(flag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 25; i++) begin
      run_op(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, r, f, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
      chk($sformatf("vec%0d_flag", i), 32'(f), 32'(vecs[i].flg));
      complete();
      chk($sformatf("vec%0d_released", i), 32'({out_valid, in_ready}), 32'b01);
    end

    // Back-pressure: result held, new in_valid ignored while out_ready is low
    run_op(3'd0, 1'b0, 8'h03, 8'h04, r, f, lat);
    chk("hold_first", 32'(r), 32'h0007);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; operation = 3'd1; op1 = 8'h01; op2 = 8'h01;
      @(posedge clk); #1;
      chk($sformatf("hold%0d_result", k), 32'(result), 32'h0007);
      chk($sformatf("hold%0d_valid_ready", k), 32'({out_valid, in_ready}), 32'b10);
    end
    complete();
    chk("hold_released", 32'({out_valid, in_ready}), 32'b01);
    @(posedge clk); #1;
    chk("hold_no_extra", 32'(out_valid), 32'd0);

    // in_valid asserted during BUSY is ignored; result reflects the accepted operands
    @(negedge clk);
    operation = 3'd4; sign = 1'b1; op1 = 8'hFD; op2 = 8'h05; in_valid = 1'b1;
    @(posedge clk); #1;
    operation = 3'd0; op1 = 8'h11; op2 = 8'h22; in_valid = 1'b1;
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_ignore_latency", 32'(lat), 32'd9);
    chk("busy_ignore_result", 32'(result), 32'hFFF1);
    complete();

    // Reset in the middle of a multiply
    @(negedge clk);
    operation = 3'd4; sign = 1'b0; op1 = 8'h0F; op2 = 8'h0F; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    operation = 3'd0; sign = 1'b0; op1 = 8'h10; op2 = 8'h20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post_reset_first_accept", 32'({out_valid, result}), {15'd0, 1'b1, 16'h0030});
    complete();
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("no_stale_result", 32'(seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; legal range 4..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  op1/op2/operation/sign are valid.
REQ-005 in_ready  output  1  block can accept a new operation.
REQ-006 op1  input  WIDTH  first operand.
REQ-007 op2  input  WIDTH  second operand, or shift amount.
REQ-008 operation  input  3  0 add, 1 sub, 2 shl, 3 shr, 4 mul, 5 div, 6-7 illegal.
REQ-009 sign  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-010 out_valid  output  1  result and flag are valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 result  output  2*WIDTH  operation result.
REQ-013 flag  output  1  overflow / divide-by-zero / illegal-op indicator.

Function
REQ-014 FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-015 Accept = in_valid && in_ready at a rising edge; operands, operation and sign are registered at accept.
REQ-016 add/sub/shl/shr/illegal: IDLE -> DONE at accept edge; out_valid high in the following cycle (latency 1).
REQ-017 mul/div: IDLE -> BUSY at accept; exactly WIDTH cycles in BUSY; then DONE; out_valid high WIDTH+1 cycles after accept.
REQ-018 DONE holds result, flag and out_valid=1 stable until out_valid && out_ready at an edge, then -> IDLE.
REQ-019 in_valid during BUSY/DONE is ignored; input changes after accept do not affect the result.
REQ-020 add/sub: low WIDTH bits = op1 +/- op2 modulo 2^WIDTH; upper WIDTH bits = sign-extension (sign=1) or zero-extension (sign=0) of the low half.
REQ-021 add/sub flag: signed overflow when sign=1; carry-out (add) or borrow (sub, op1<op2) when sign=0.
REQ-022 shl/shr: amount = op2 as unsigned; low half = shifted op1, upper half extended per REQ-020; shr arithmetic when sign=1, logical otherwise.
REQ-023 Shift amount >= WIDTH: result fill = all zeros, except shr with sign=1 gives all copies of op1 MSB; flag = 0.
REQ-024 mul: full 2*WIDTH-bit product, signed per sign; flag = 0.
REQ-025 div: result[WIDTH-1:0] = quotient, result[2*WIDTH-1:WIDTH] = remainder; truncation toward zero, remainder takes sign of op1 when sign=1.
REQ-026 div by zero: quotient all ones, remainder = op1, flag = 1, latency unchanged.
REQ-027 Signed div of most-negative by -1: quotient = most-negative, remainder 0, flag = 1.
REQ-028 Illegal operation: result 0, flag 1.
REQ-029 Signed mul/div computed on magnitudes with final conditional negation inside the WIDTH-cycle window.

Reset
REQ-030 rst_n low forces state IDLE, in_ready 1, out_valid 0, result 0, flag 0, clearing any in-flight operation with no output produced.
REQ-031 First accept possible at the first rising edge after rst_n deasserts.

Structure
REQ-032 Package seq_alu_pkg holds the operation enum (ALU_ADD..ALU_DIV), FSM state enum and opcode width constant.
REQ-033 Iterative shift-add multiplier / restoring divider lives in sub-module seq_alu_muldiv (start, done, 2*WIDTH result, one bit per cycle).

Verification (WIDTH=8)
REQ-034 sign=1, add 8'h7F+8'h01 -> result 16'hFF80, flag 1, out_valid 1 cycle after accept.
REQ-035 sign=1, mul 8'hFD (-3) x 8'h05 -> result 16'hFFF1, flag 0, out_valid 9 cycles after accept.
REQ-036 sign=0, div 8'd200 / 8'd7 -> result {8'd4, 8'd28}; div by 0 with op1=8'h2A -> result 16'h2AFF, flag 1.
REQ-037 sign=1, shr 8'h90 by 8'd9 -> result 16'hFFFF, flag 0; sign=0 same -> 16'h0000.
REQ-038 out_ready held low 5 cycles after out_valid -> result stable, in_ready 0, new in_valid ignored; completes on out_ready.
REQ-039 rst_n pulsed low mid-BUSY of a mul -> out_valid 0, in_ready 1 immediately; no stale result after release.
